mac_stream_acc: RTL and testbench
=================================

# mac_stream_acc

Parametrised successor to the matrix MAC top. It computes C = A·B, or C += A·B, for an M×K by K×N matrix product. Operands are signed or unsigned and selected per job; accumulator width is configurable. A single-beat load handshake accepts both operand matrices. C is returned row by row over a valid/ready stream instead of one flat bus, and stays resident between jobs so results can be accumulated across several loads.

## Interface
- M, 4, rows of A and C
- K, 4, inner dimension
- N, 4, columns of B and C
- DATA_WIDTH, 8, operand element width
- ACC_WIDTH, 2*DATA_WIDTH+8, C element width; must be ≥ 2*DATA_WIDTH
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- host2block_val  in  1  load request
- host2block_rdy  out  1  block idle, load accepted on val&&rdy
- a_data_in_ext  in  M*K*DATA_WIDTH  A[r][k] at element index r*K+k, element i at [i*DATA_WIDTH +: DATA_WIDTH]
- b_data_in_ext  in  K*N*DATA_WIDTH  B supplied transposed: B[k][j] at element index j*K+k
- signed_mode  in  1  1 = two's-complement operands; sampled at load handshake
- acc_mode  in  1  1 = C += A·B, 0 = C = A·B; sampled at load handshake
- clear_acc  in  1  zero all of C; honoured only while idle
- busy  out  1  job in progress (COMPUTE, FLUSH or OUTPUT)
- mac_done  out  1  one-cycle pulse when C is final
- block2host_val  out  1  row beat valid
- block2host_rdy  in  1  host accepts row beat
- c_row_out  out  N*ACC_WIDTH  C[r][j] at [j*ACC_WIDTH +: ACC_WIDTH]
- c_row_idx  out  max(1,$clog2(M))  current row r
- c_last  out  1  high with beat r = M-1

## Operation
- States: IDLE, COMPUTE, FLUSH, OUTPUT.
- IDLE: host2block_rdy=1.
  - On val&&rdy: latch A, B, signed_mode and acc_mode; go to COMPUTE.
  - Input changes after the handshake are ignored.
- COMPUTE: element counter e = 0..M*N-1, one element issued per cycle, with row r = e/N and column j = e%N.
  - Stage 1 registers K products A[r][k]*B[k][j], each 2*DATA_WIDTH bits. Operands are sign-extended in signed mode and zero-extended otherwise.
  - Stage 2 computes the sum of the K products plus (acc_mode ? C[e] : 0), extends it to ACC_WIDTH, and writes C[e].
  - Arithmetic wraps modulo 2^ACC_WIDTH. There is no saturation and no overflow flag.
  - After e = M*N-1 is issued, go to FLUSH.
- FLUSH: one cycle, in which the last stage-2 write completes. Then go to OUTPUT.
- OUTPUT:
  - The first cycle asserts mac_done for exactly one cycle.
  - block2host_val=1 with row r, starting at r=0.
  - Row advances on val&&rdy. The handshake on r = M-1 returns the block to IDLE.
  - All row outputs are held stable while val && !rdy.
- clear_acc:
  - In IDLE, C is zeroed at the next edge.
  - If asserted together with a load handshake, the clear applies first, so an acc_mode job accumulates onto zero.
  - Ignored in every other state.
- C persists across jobs; only clear_acc and reset modify it outside COMPUTE.
- c_row_out, c_row_idx and c_last are driven from C and the row counter in every state. Their values are meaningful only while block2host_val=1.

## Timing
- Reset (asynchronous, effective immediately, including mid-job):
  - State returns to IDLE, C is zeroed, and the counters are zeroed.
  - host2block_rdy=0, busy=0, mac_done=0, block2host_val=0, c_last=0, c_row_idx=0, c_row_out=0.
  - host2block_rdy is registered and rises at the first rising edge after rstn deasserts.
- Load handshake at edge T0:
  - rdy=0 and busy=1 from cycle T0+1.
  - Element e is issued in cycle T0+1+e and written to C at the end of cycle T0+2+e.
  - FLUSH occupies cycle T0+M*N+1.
  - mac_done and the first block2host_val both occur in cycle T0+M*N+2.
- Output with block2host_rdy held at 1: M beats in M consecutive cycles.
- host2block_rdy=1 and busy=0 from the cycle after the last beat handshake. A new load is possible at that edge at the earliest.
- Throughput: M*N+2+M cycles per job with no output backpressure.

## Test plan
- Product: default parameters, unsigned, acc_mode=0, a_data_in_ext element i = i, b_data_in_ext = transpose of the logical matrix B with B[k][j] = 4k+j.
  - Required rows: [56,62,68,74], [152,174,196,218], [248,286,324,362], [344,398,452,506].
  - mac_done in cycle T0+18.
- Accumulate: repeat the load above with acc_mode=1.
  - Rows double; row 0 = [112,124,136,148], row 3 = [688,796,904,1012].
- Sign/width:
  - All A=0xFF, all B=0x02, signed, acc_mode=0: every element 0xFFFFF8 (-8).
  - Same operands unsigned: every element 2040.
  - ACC_WIDTH=16, A=B=0xFF unsigned: every element 63492 (wrap).
- Backpressure: drop block2host_rdy for 5 cycles while row 1 is presented.
  - c_row_idx stays 1 and the data is stable.
  - c_last is high only with row 3.
  - host2block_rdy stays 0 until the cycle after the row-3 handshake.
- Clear: clear_acc=1 in the same cycle as an acc_mode=1 load over a non-zero C.
  - Result equals the plain product.
  - clear_acc pulsed during COMPUTE has no effect.
- Reset mid-job: drop rstn in cycle T0+8.
  - All outputs go to 0 immediately.
  - rdy rises one edge after release.
  - A subsequent acc_mode=1 load returns the plain product, proving C was zeroed.

Source files
------------

// File: rtl/mac_stream_acc.sv
// mac_stream_acc: streaming matrix multiply-accumulate, C = A*B or C += A*B.
// Operand matrices are loaded in one handshake. C is computed one element
// per cycle through a two-stage pipeline, then returned row by row over a
// valid/ready stream. C stays resident between jobs.
module mac_stream_acc #(
    parameter int M          = 4,
    parameter int K          = 4,
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+8
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic                                   host2block_val,
    output logic                                   host2block_rdy,
    input  logic [M*K*DATA_WIDTH-1:0]              a_data_in_ext,
    input  logic [K*N*DATA_WIDTH-1:0]              b_data_in_ext,
    input  logic                                   signed_mode,
    input  logic                                   acc_mode,
    input  logic                                   clear_acc,
    output logic                                   busy,
    output logic                                   mac_done,
    output logic                                   block2host_val,
    input  logic                                   block2host_rdy,
    output logic [N*ACC_WIDTH-1:0]                 c_row_out,
    output logic [((M > 1) ? $clog2(M) : 1)-1:0]   c_row_idx,
    output logic                                   c_last
);

    localparam int RW = (M > 1) ? $clog2(M) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int EW = (M*N > 1) ? $clog2(M*N) : 1;
    localparam int PW = 2*DATA_WIDTH;

    localparam logic [RW-1:0] ROW_MAX  = RW'(M-1);
    localparam logic [CW-1:0] COL_MAX  = CW'(N-1);
    localparam logic [EW-1:0] ELEM_MAX = EW'(M*N-1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_FLUSH   = 2'd2;
    localparam logic [1:0] S_OUTPUT  = 2'd3;

    logic [1:0]                  state_r;
    logic                        rdy_r;
    logic                        busy_r;
    logic                        done_r;
    logic                        val_r;
    logic [M*K*DATA_WIDTH-1:0]   a_r;
    logic [K*N*DATA_WIDTH-1:0]   b_r;
    logic                        sgn_r;
    logic                        acc_r;
    logic [EW-1:0]               e_r;
    logic [RW-1:0]               er_r;
    logic [CW-1:0]               ec_r;
    logic [RW-1:0]               orow_r;
    logic [PW-1:0]               prod_s [K];
    logic [PW-1:0]               prod_r [K];
    logic                        s1_val_r;
    logic [EW-1:0]               s1_e_r;
    logic [ACC_WIDTH-1:0]        sum_s;
    logic [ACC_WIDTH-1:0]        c_mem_r [M*N];

    // Extend both operands to product width per mode, then multiply.
    function automatic logic [PW-1:0] mul_ext(input logic [DATA_WIDTH-1:0] a,
                                              input logic [DATA_WIDTH-1:0] b,
                                              input logic                  sgn);
        logic [PW-1:0] ax;
        logic [PW-1:0] bx;
        if (sgn) begin
            ax = PW'($signed(a));
            bx = PW'($signed(b));
        end else begin
            ax = PW'(a);
            bx = PW'(b);
        end
        return ax * bx;
    endfunction

    // Extend a product to accumulator width per mode.
    function automatic logic [ACC_WIDTH-1:0] ext_acc(input logic [PW-1:0] p,
                                                     input logic          sgn);
        if (sgn) begin
            return ACC_WIDTH'($signed(p));
        end else begin
            return ACC_WIDTH'(p);
        end
    endfunction

    // Control FSM: load handshake, element issue, flush, row streaming.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= S_IDLE;
            rdy_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            val_r   <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            sgn_r   <= 1'b0;
            acc_r   <= 1'b0;
            e_r     <= '0;
            er_r    <= '0;
            ec_r    <= '0;
            orow_r  <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    rdy_r <= 1'b1;
                    if (host2block_val && rdy_r) begin
                        a_r     <= a_data_in_ext;
                        b_r     <= b_data_in_ext;
                        sgn_r   <= signed_mode;
                        acc_r   <= acc_mode;
                        rdy_r   <= 1'b0;
                        busy_r  <= 1'b1;
                        e_r     <= '0;
                        er_r    <= '0;
                        ec_r    <= '0;
                        state_r <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    if (e_r == ELEM_MAX) begin
                        state_r <= S_FLUSH;
                    end else begin
                        e_r <= e_r + 1'b1;
                        if (ec_r == COL_MAX) begin
                            ec_r <= '0;
                            er_r <= er_r + 1'b1;
                        end else begin
                            ec_r <= ec_r + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    done_r  <= 1'b1;
                    val_r   <= 1'b1;
                    orow_r  <= '0;
                    state_r <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    if (val_r && block2host_rdy) begin
                        if (orow_r == ROW_MAX) begin
                            val_r   <= 1'b0;
                            orow_r  <= '0;
                            busy_r  <= 1'b0;
                            rdy_r   <= 1'b1;
                            state_r <= S_IDLE;
                        end else begin
                            orow_r <= orow_r + 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    val_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Stage-1 operand selection and K parallel products for the issued element.
    always_comb begin
        for (int k = 0; k < K; k++) begin
            prod_s[k] = mul_ext(a_r[(int'(er_r)*K + k)*DATA_WIDTH +: DATA_WIDTH],
                                b_r[(int'(ec_r)*K + k)*DATA_WIDTH +: DATA_WIDTH],
                                sgn_r);
        end
    end

    // Stage-1 pipeline register: products plus the element they belong to.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_val_r <= 1'b0;
            s1_e_r   <= '0;
            for (int k = 0; k < K; k++) begin
                prod_r[k] <= '0;
            end
        end else begin
            s1_val_r <= (state_r == S_COMPUTE);
            s1_e_r   <= e_r;
            for (int k = 0; k < K; k++) begin
                prod_r[k] <= prod_s[k];
            end
        end
    end

    // Stage-2 reduction: sum of products plus the old C element when accumulating.
    always_comb begin
        if (acc_r) begin
            sum_s = c_mem_r[s1_e_r];
        end else begin
            sum_s = '0;
        end
        for (int k = 0; k < K; k++) begin
            sum_s = sum_s + ext_acc(prod_r[k], sgn_r);
        end
    end

    // Resident C storage: idle clear has priority, otherwise stage-2 write-back.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < M*N; i++) begin
                c_mem_r[i] <= '0;
            end
        end else if ((state_r == S_IDLE) && clear_acc) begin
            for (int i = 0; i < M*N; i++) begin
                c_mem_r[i] <= '0;
            end
        end else if (s1_val_r) begin
            c_mem_r[s1_e_r] <= sum_s;
        end
    end

    // Row view of C selected by the output row counter.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            c_row_out[j*ACC_WIDTH +: ACC_WIDTH] = c_mem_r[int'(orow_r)*N + j];
        end
    end

    assign host2block_rdy = rdy_r;
    assign busy           = busy_r;
    assign mac_done       = done_r;
    assign block2host_val = val_r;
    assign c_row_idx      = orow_r;
    assign c_last         = val_r && (orow_r == ROW_MAX);

endmodule

// File: tb/tb_mac_stream_acc.sv
// Scoreboard bench for mac_stream_acc: directed jobs push hand-computed rows
// into queues; monitors pop and compare on every accepted row beat.
module tb_mac_stream_acc;

    localparam int M = 4, K = 4, N = 4, DW = 8, ACC = 24, ACC16 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rstn, val, rdy, val16, rdy16;
    logic [M*K*DW-1:0]    a_in;
    logic [K*N*DW-1:0]    b_in;
    logic                 sgn, accm, clr;
    logic                 busy, done, oval, last, out_rdy;
    logic                 busy16, done16, oval16, last16, out_rdy16;
    logic [N*ACC-1:0]     row;
    logic [N*ACC16-1:0]   row16;
    logic [1:0]           idx, idx16;

    int total = 0;
    int bad   = 0;

    typedef struct packed { logic [N*ACC-1:0] row; logic [1:0] idx; logic last; } exp_t;
    typedef struct packed { logic [N*ACC16-1:0] row; logic [1:0] idx; logic last; } exp16_t;
    exp_t   q[$];
    exp16_t q16[$];

    logic [N*ACC-1:0] prod_rows [M];
    logic [N*ACC-1:0] dbl_rows  [M];

    mac_stream_acc u_dut (
        .clk(clk), .rstn(rstn), .host2block_val(val), .host2block_rdy(rdy),
        .a_data_in_ext(a_in), .b_data_in_ext(b_in), .signed_mode(sgn),
        .acc_mode(accm), .clear_acc(clr), .busy(busy), .mac_done(done),
        .block2host_val(oval), .block2host_rdy(out_rdy), .c_row_out(row),
        .c_row_idx(idx), .c_last(last)
    );

    mac_stream_acc #(.ACC_WIDTH(ACC16)) u_dut16 (
        .clk(clk), .rstn(rstn), .host2block_val(val16), .host2block_rdy(rdy16),
        .a_data_in_ext(a_in), .b_data_in_ext(b_in), .signed_mode(sgn),
        .acc_mode(accm), .clear_acc(clr), .busy(busy16), .mac_done(done16),
        .block2host_val(oval16), .block2host_rdy(out_rdy16), .c_row_out(row16),
        .c_row_idx(idx16), .c_last(last16)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [N*ACC-1:0] pack(input int e0, input int e1, input int e2, input int e3);
        logic [N*ACC-1:0] r;
        r[0*ACC +: ACC] = ACC'(e0);
        r[1*ACC +: ACC] = ACC'(e1);
        r[2*ACC +: ACC] = ACC'(e2);
        r[3*ACC +: ACC] = ACC'(e3);
        return r;
    endfunction

    function automatic logic [M*K*DW-1:0] a_ramp();
        logic [M*K*DW-1:0] a;
        for (int i = 0; i < M*K; i++) a[i*DW +: DW] = DW'(i);
        return a;
    endfunction

    function automatic logic [K*N*DW-1:0] b_ramp();
        logic [K*N*DW-1:0] b;
        for (int j = 0; j < N; j++)
            for (int k = 0; k < K; k++)
                b[(j*K + k)*DW +: DW] = DW'(4*k + j);
        return b;
    endfunction

    task automatic push_rows(input logic [N*ACC-1:0] r0, input logic [N*ACC-1:0] r1,
                             input logic [N*ACC-1:0] r2, input logic [N*ACC-1:0] r3);
        q.push_back('{row: r0, idx: 2'd0, last: 1'b0});
        q.push_back('{row: r1, idx: 2'd1, last: 1'b0});
        q.push_back('{row: r2, idx: 2'd2, last: 1'b0});
        q.push_back('{row: r3, idx: 2'd3, last: 1'b1});
    endtask

    // Main-DUT monitor: every accepted beat is compared against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rstn && oval && out_rdy) begin
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_beat actual idx=%0d required=no beat", idx);
            end else begin
                e = q.pop_front();
                check("row_data", row, e.row);
                check("row_idx", idx, e.idx);
                check("row_last", last, e.last);
            end
        end
    end

    // Narrow-accumulator monitor.
    always @(negedge clk) begin
        exp16_t e;
        if (rstn && oval16 && out_rdy16) begin
            if (q16.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_beat16 actual idx=%0d required=no beat", idx16);
            end else begin
                e = q16.pop_front();
                check("row16_data", row16, e.row);
                check("row16_idx", idx16, e.idx);
                check("row16_last", last16, e.last);
            end
        end
    end

    task automatic wait_rdy();
        int n = 0;
        @(negedge clk);
        while (!rdy && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!rdy) begin
            total++; bad++;
            $display("FAIL wait_rdy actual=timeout required=rdy");
        end
    endtask

    // Load at a negedge; the following posedge is the handshake edge T0.
    task automatic load(input logic [M*K*DW-1:0] a, input logic [K*N*DW-1:0] b,
                        input logic s, input logic ac, input logic cl);
        wait_rdy();
        a_in = a; b_in = b; sgn = s; accm = ac; clr = cl; val = 1'b1;
        @(posedge clk); #1;
        val = 1'b0; clr = 1'b0; a_in = ~a; b_in = ~b; sgn = ~s; accm = ~ac;
    endtask

    // Counts cycles from T0 until mac_done is seen.
    task automatic wait_done(input int exp_n);
        int i = 0;
        bit seen = 1'b0;
        while (!seen && i < 100) begin
            @(negedge clk);
            i++;
            if (i == 1) begin
                check("busy_in_compute", busy, 1);
                check("rdy_low_in_compute", rdy, 0);
            end
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL mac_done_timeout actual=none required=cycle %0d", exp_n);
        end else begin
            check("mac_done_cycle", i, exp_n);
        end
    endtask

    // Walks the remaining output beats, then checks the return to idle.
    task automatic wait_end(input int exp_beats);
        int n = 0;
        while (oval && n < 100) begin
            check("rdy_low_while_out", rdy, 0);
            if (n > 0) check("done_one_pulse", done, 0);
            n++;
            @(negedge clk);
        end
        if (oval) begin
            total++; bad++;
            $display("FAIL output_timeout actual=val stuck required=val low");
        end
        check("rdy_after_last", rdy, 1);
        check("busy_after_last", busy, 0);
        if (exp_beats > 0) check("beat_cycles", n, exp_beats);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        prod_rows[0] = pack(56, 62, 68, 74);
        prod_rows[1] = pack(152, 174, 196, 218);
        prod_rows[2] = pack(248, 286, 324, 362);
        prod_rows[3] = pack(344, 398, 452, 506);
        dbl_rows[0]  = pack(112, 124, 136, 148);
        dbl_rows[1]  = pack(304, 348, 392, 436);
        dbl_rows[2]  = pack(496, 572, 648, 724);
        dbl_rows[3]  = pack(688, 796, 904, 1012);

        val = 1'b0; val16 = 1'b0; sgn = 1'b0; accm = 1'b0; clr = 1'b0;
        a_in = '0; b_in = '0; out_rdy = 1'b1; out_rdy16 = 1'b1;
        rstn = 1'b1;
        #2 rstn = 1'b0;
        #1;
        check("rst_rdy", rdy, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_val", oval, 0);
        check("rst_last", last, 0);
        check("rst_idx", idx, 0);
        check("rst_row", row, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rstn = 1'b1;
        #1 check("rdy_before_edge", rdy, 0);
        @(posedge clk); #1 check("rdy_after_edge", rdy, 1);

        // Plain product with backpressure on row 1.
        push_rows(prod_rows[0], prod_rows[1], prod_rows[2], prod_rows[3]);
        load(a_ramp(), b_ramp(), 1'b0, 1'b0, 1'b0);
        wait_done(18);
        @(posedge clk); #1 out_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_idx", idx, 1);
            check("bp_row", row, prod_rows[1]);
            check("bp_val", oval, 1);
            check("bp_last", last, 0);
            check("bp_rdy", rdy, 0);
            @(posedge clk);
        end
        #1 out_rdy = 1'b1;
        @(negedge clk);
        wait_end(0);

        // Narrow accumulator wraps modulo 2^16.
        wait_rdy();
        a_in = {16{8'hFF}}; b_in = {16{8'hFF}}; sgn = 1'b0; accm = 1'b0; val16 = 1'b1;
        for (int r = 0; r < M; r++)
            q16.push_back('{row: {4{16'd63492}}, idx: 2'(r), last: (r == M-1)});
        @(posedge clk); #1 val16 = 1'b0;
        for (int c = 0; c < 60; c++) @(negedge clk);
        check("q16_drained", q16.size(), 0);

        // Accumulate onto the resident product.
        push_rows(dbl_rows[0], dbl_rows[1], dbl_rows[2], dbl_rows[3]);
        load(a_ramp(), b_ramp(), 1'b0, 1'b1, 1'b0);
        wait_done(18);
        wait_end(M);

        // Signed: -1 * 2 summed four times.
        push_rows(pack(32'hFFFFF8, 32'hFFFFF8, 32'hFFFFF8, 32'hFFFFF8),
                  pack(32'hFFFFF8, 32'hFFFFF8, 32'hFFFFF8, 32'hFFFFF8),
                  pack(32'hFFFFF8, 32'hFFFFF8, 32'hFFFFF8, 32'hFFFFF8),
                  pack(32'hFFFFF8, 32'hFFFFF8, 32'hFFFFF8, 32'hFFFFF8));
        load({16{8'hFF}}, {16{8'h02}}, 1'b1, 1'b0, 1'b0);
        wait_done(18);
        wait_end(M);

        // Same operands unsigned.
        push_rows(pack(2040, 2040, 2040, 2040), pack(2040, 2040, 2040, 2040),
                  pack(2040, 2040, 2040, 2040), pack(2040, 2040, 2040, 2040));
        load({16{8'hFF}}, {16{8'h02}}, 1'b0, 1'b0, 1'b0);
        wait_done(18);
        wait_end(M);

        // Clear with an accumulate load; a clear during compute is ignored.
        push_rows(prod_rows[0], prod_rows[1], prod_rows[2], prod_rows[3]);
        load(a_ramp(), b_ramp(), 1'b0, 1'b1, 1'b1);
        fork
            begin
                @(posedge clk); #1 clr = 1'b1;
                @(posedge clk); #1 clr = 1'b0;
            end
        join_none
        wait_done(18);
        wait_end(M);

        // Reset mid-job, then accumulate onto the zeroed C.
        load(a_ramp(), b_ramp(), 1'b0, 1'b0, 1'b0);
        repeat (7) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_rdy", rdy, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_val", oval, 0);
        check("mid_rst_last", last, 0);
        check("mid_rst_idx", idx, 0);
        check("mid_rst_row", row, 0);
        @(negedge clk); rstn = 1'b1;
        #1 check("mid_rdy_before_edge", rdy, 0);
        @(posedge clk); #1 check("mid_rdy_after_edge", rdy, 1);
        push_rows(prod_rows[0], prod_rows[1], prod_rows[2], prod_rows[3]);
        load(a_ramp(), b_ramp(), 1'b0, 1'b1, 1'b0);
        wait_done(18);
        wait_end(M);

        repeat (3) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
